// File: rtl/vxe_mem_responder.sv
// Memory-side endpoint of the VxE client memory protocol: posted byte-enabled writes, fixed-latency reads.
// Optional client-backpressure stress generator is enabled by defining VXE_MEMRESP_STALL_EN.
`timescale 1ns/1ps
module vxe_mem_responder #(
  parameter int MEM_AW        = 10,
  parameter int READ_LAT      = 4,
  parameter int RS_DEPTH_POW2 = 3,
  parameter int WD_DEPTH_POW2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_rqa_rdy,
  input  logic [43:0] i_rqa,
  input  logic        i_rqa_wr,
  output logic        o_rqd_rdy,
  input  logic [71:0] i_rqd,
  input  logic        i_rqd_wr,
  output logic        o_rss_vld,
  output logic [8:0]  o_rss,
  input  logic        i_rss_rd,
  output logic        o_rsd_vld,
  output logic [63:0] o_rsd,
  input  logic        i_rsd_rd,
  output logic        o_err
);

  localparam int RS_DEPTH = 1 << RS_DEPTH_POW2;
  localparam int WD_DEPTH = 1 << WD_DEPTH_POW2;
  localparam int CW       = RS_DEPTH_POW2 + 1;
  localparam int WW       = WD_DEPTH_POW2 + 1;

  typedef struct packed {
    logic              vld;
    logic [1:0]        cid;
    logic [2:0]        th;
    logic              arg;
    logic              err;
    logic [MEM_AW-1:0] idx;
  } rd_stage_t;

  logic stall;
`ifdef VXE_MEMRESP_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  logic              rq_rnw;
  logic [1:0]        rq_cid;
  logic [2:0]        rq_th;
  logic              rq_arg;
  logic [36:0]       rq_addr;
  logic [MEM_AW-1:0] rq_idx;
  logic              rq_range_err;

  assign {rq_rnw, rq_cid, rq_th, rq_arg, rq_addr} = i_rqa;
  assign rq_idx       = rq_addr[MEM_AW-1:0];
  assign rq_range_err = (rq_addr >> MEM_AW) != 37'd0;

  logic          pend_wr;
  logic [CW-1:0] credits;
  logic          wd_full, wd_empty, wd_pop;
  logic          rqa_xfer, rqd_xfer, rd_acc, wr_acc;

  assign o_rqa_rdy = !pend_wr && (credits != '0) && !rst && !stall;
  assign o_rqd_rdy = !wd_full && !stall;
  assign rqa_xfer  = i_rqa_wr && o_rqa_rdy;
  assign rqd_xfer  = i_rqd_wr && o_rqd_rdy;
  assign rd_acc    = rqa_xfer && rq_rnw;
  assign wr_acc    = rqa_xfer && !rq_rnw;

  // Write-data FIFO
  logic [71:0]              wd_mem [WD_DEPTH];
  logic [WD_DEPTH_POW2-1:0] wd_wptr, wd_rptr;
  logic [WW-1:0]            wd_cnt;
  logic [71:0]              wd_head;

  assign wd_full  = wd_cnt == WW'(WD_DEPTH);
  assign wd_empty = wd_cnt == '0;
  assign wd_head  = wd_mem[wd_rptr];

  // NOTE: storage arrays carry no reset; only pointers and counters are reset, so arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rqd_xfer) wd_mem[wd_wptr] <= i_rqd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_wptr <= '0;
      wd_rptr <= '0;
      wd_cnt  <= '0;
    end else begin
      if (rqd_xfer) wd_wptr <= wd_wptr + 1'b1;
      if (wd_pop)   wd_rptr <= wd_rptr + 1'b1;
      wd_cnt <= wd_cnt + WW'(rqd_xfer) - WW'(wd_pop);
    end
  end

  // Write commit: immediate when data is waiting, otherwise parked in pend_wr until data arrives.
  logic [MEM_AW-1:0] pend_idx, commit_idx;
  logic              pend_err, commit_err, commit_en;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    wd_pop     = 1'b0;
    commit_idx = rq_idx;
    commit_err = rq_range_err;
    if (pend_wr) begin
      commit_idx = pend_idx;
      commit_err = pend_err;
      wd_pop     = !wd_empty && !rst;
    end else if (wr_acc) begin
      wd_pop     = !wd_empty;
    end
    commit_en = wd_pop && !commit_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr  <= 1'b0;
      pend_idx <= '0;
      pend_err <= 1'b0;
    end else if (wr_acc && wd_empty) begin
      pend_wr  <= 1'b1;
      pend_idx <= rq_idx;
      pend_err <= rq_range_err;
    end else if (pend_wr && !wd_empty) begin
      pend_wr  <= 1'b0;
    end
  end

  logic [63:0] ram [2**MEM_AW];
  always_ff @(posedge clk) begin
    if (commit_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wd_head[64+b]) ram[commit_idx][8*b +: 8] <= wd_head[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                           o_err <= 1'b0;
    else if (rqa_xfer && rq_range_err) o_err <= 1'b1;
  end

  // Read pipeline; the RAM is sampled as an entry leaves the last stage.
  rd_stage_t acc_stage, fin_stage;
  assign acc_stage = '{vld: rd_acc, cid: rq_cid, th: rq_th, arg: rq_arg,
                       err: rq_range_err, idx: rq_idx};

  if (READ_LAT == 1) begin : g_lat1
    assign fin_stage = acc_stage;
  end else begin : g_pipe
    rd_stage_t pipe [READ_LAT-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < READ_LAT-1; s++) pipe[s] <= '0;
      end else begin
        pipe[0] <= acc_stage;
        for (int s = 1; s < READ_LAT-1; s++) pipe[s] <= pipe[s-1];
      end
    end
    assign fin_stage = pipe[READ_LAT-2];
  end

  // Response FIFOs: pushed together, popped independently.
  logic                     rs_push, rss_pop, rsd_pop;
  logic [8:0]               rss_mem [RS_DEPTH];
  logic [63:0]              rsd_mem [RS_DEPTH];
  logic [RS_DEPTH_POW2-1:0] rs_wptr, rss_rptr, rsd_rptr;
  logic [CW-1:0]            rss_cnt, rsd_cnt;

  assign rs_push   = fin_stage.vld;
  assign o_rss_vld = rss_cnt != '0;
  assign o_rsd_vld = rsd_cnt != '0;
  assign o_rss     = o_rss_vld ? rss_mem[rss_rptr] : '0;
  assign o_rsd     = o_rsd_vld ? rsd_mem[rsd_rptr] : '0;
  assign rss_pop   = i_rss_rd && o_rss_vld;
  assign rsd_pop   = i_rsd_rd && o_rsd_vld;

  always_ff @(posedge clk) begin
    if (rs_push) begin
      rss_mem[rs_wptr] <= {fin_stage.err, fin_stage.cid, fin_stage.th, fin_stage.arg, 2'b00};
      rsd_mem[rs_wptr] <= fin_stage.err ? 64'd0 : ram[fin_stage.idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_wptr  <= '0;
      rss_rptr <= '0;
      rsd_rptr <= '0;
      rss_cnt  <= '0;
      rsd_cnt  <= '0;
    end else begin
      if (rs_push) rs_wptr  <= rs_wptr + 1'b1;
      if (rss_pop) rss_rptr <= rss_rptr + 1'b1;
      if (rsd_pop) rsd_rptr <= rsd_rptr + 1'b1;
      rss_cnt <= rss_cnt + CW'(rs_push) - CW'(rss_pop);
      rsd_cnt <= rsd_cnt + CW'(rs_push) - CW'(rsd_pop);
    end
  end

  // Pop-lead counters are sized to hold a whole FIFO of lead, so one side may drain fully first.
  logic [CW-1:0] rss_lead, rsd_lead, rss_lead_nxt, rsd_lead_nxt;
  logic          crd_ret;

  always_comb begin
    crd_ret      = 1'b0;
    rss_lead_nxt = rss_lead;
    rsd_lead_nxt = rsd_lead;
    if (rss_pop && rsd_pop) begin
      crd_ret = 1'b1;
    end else if (rss_pop) begin
      if (rsd_lead != '0) begin
        rsd_lead_nxt = rsd_lead - 1'b1;
        crd_ret      = 1'b1;
      end else begin
        rss_lead_nxt = rss_lead + 1'b1;
      end
    end else if (rsd_pop) begin
      if (rss_lead != '0) begin
        rss_lead_nxt = rss_lead - 1'b1;
        crd_ret      = 1'b1;
      end else begin
        rsd_lead_nxt = rsd_lead + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rss_lead <= '0;
      rsd_lead <= '0;
      credits  <= CW'(RS_DEPTH);
    end else begin
      rss_lead <= rss_lead_nxt;
      rsd_lead <= rsd_lead_nxt;
      credits  <= credits - CW'(rd_acc) + CW'(crd_ret);
    end
  end

endmodule

// File: tb/tb_vxe_mem_responder.sv
// Self-checking bench for vxe_mem_responder: scenario tasks plus a response scoreboard.
`timescale 1ns/1ps
module tb_vxe_mem_responder;

  localparam int MEM_AW        = 10;
  localparam int READ_LAT      = 4;
  localparam int RS_DEPTH_POW2 = 3;
  localparam int WD_DEPTH_POW2 = 2;
  localparam int RS_DEPTH      = 1 << RS_DEPTH_POW2;
  localparam int WD_DEPTH      = 1 << WD_DEPTH_POW2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_rqa_rdy, o_rqd_rdy, o_rss_vld, o_rsd_vld, o_err;
  logic [43:0] i_rqa    = '0;
  logic        i_rqa_wr = 1'b0;
  logic [71:0] i_rqd    = '0;
  logic        i_rqd_wr = 1'b0;
  logic [8:0]  o_rss;
  logic [63:0] o_rsd;
  logic        i_rss_rd = 1'b1;
  logic        i_rsd_rd = 1'b1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [8:0]  exp_rss_q [$];
  logic [63:0] exp_rsd_q [$];
  logic [63:0] mdl [2**MEM_AW];

  vxe_mem_responder #(
    .MEM_AW(MEM_AW), .READ_LAT(READ_LAT),
    .RS_DEPTH_POW2(RS_DEPTH_POW2), .WD_DEPTH_POW2(WD_DEPTH_POW2)
  ) dut (
    .clk(clk), .rst(rst),
    .o_rqa_rdy(o_rqa_rdy), .i_rqa(i_rqa), .i_rqa_wr(i_rqa_wr),
    .o_rqd_rdy(o_rqd_rdy), .i_rqd(i_rqd), .i_rqd_wr(i_rqd_wr),
    .o_rss_vld(o_rss_vld), .o_rss(o_rss), .i_rss_rd(i_rss_rd),
    .o_rsd_vld(o_rsd_vld), .o_rsd(o_rsd), .i_rsd_rd(i_rsd_rd),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: each pop is checked against the oldest expectation of that stream.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_rss_rd && o_rss_vld) begin
        n_cmp++;
        if (exp_rss_q.size() == 0) begin
          n_bad++;
          $display("FAIL rss_unexpected: got %h, no response expected", o_rss);
        end else begin
          logic [8:0] e;
          e = exp_rss_q.pop_front();
          if (o_rss !== e) begin
            n_bad++;
            $display("FAIL rss_data: got %h, expected %h", o_rss, e);
          end
        end
      end
      if (i_rsd_rd && o_rsd_vld) begin
        n_cmp++;
        if (exp_rsd_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsd_unexpected: got %h, no response expected", o_rsd);
        end else begin
          logic [63:0] e;
          e = exp_rsd_q.pop_front();
          if (o_rsd !== e) begin
            n_bad++;
            $display("FAIL rsd_data: got %h, expected %h", o_rsd, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit in_range(input logic [36:0] addr);
    return (addr >> MEM_AW) == 37'd0;
  endfunction

  task automatic send_rqa(input logic [43:0] rq, input int budget, output bit ok);
    int n;
    n = 0;
    while (!o_rqa_rdy && n < budget) begin tick(); n++; end
    ok = o_rqa_rdy;
    if (ok) begin
      i_rqa = rq; i_rqa_wr = 1'b1;
      tick();
      i_rqa_wr = 1'b0;
    end
  endtask

  task automatic send_rqd(input logic [63:0] d, input logic [7:0] be, output bit ok);
    int n;
    n = 0;
    while (!o_rqd_rdy && n < 32) begin tick(); n++; end
    ok = o_rqd_rdy;
    if (ok) begin
      i_rqd = {be, d}; i_rqd_wr = 1'b1;
      tick();
      i_rqd_wr = 1'b0;
    end
  endtask

  task automatic issue_read(input logic [36:0] addr, input logic [1:0] cid, input logic [2:0] th,
                            input logic arg, input int budget, output bit ok);
    logic err;
    logic [9:0] idx;
    send_rqa({1'b1, cid, th, arg, addr}, budget, ok);
    if (ok) begin
      err = !in_range(addr);
      idx = addr[9:0];
      exp_rss_q.push_back({err, cid, th, arg, 2'b00});
      exp_rsd_q.push_back(err ? 64'd0 : mdl[idx]);
    end
  endtask

  task automatic issue_write(input logic [36:0] addr, input logic [63:0] d, input logic [7:0] be);
    bit ok1, ok2;
    logic [9:0] idx;
    send_rqd(d, be, ok1);
    send_rqa({1'b0, 2'd0, 3'd0, 1'b0, addr}, 32, ok2);
    n_cmp++;
    if (!(ok1 && ok2)) begin
      n_bad++;
      $display("FAIL write_accept: data_ok=%0d addr_ok=%0d, expected both 1", ok1, ok2);
    end else if (in_range(addr)) begin
      idx = addr[9:0];
      mdl[idx] = merge(mdl[idx], d, be);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_rss_q.size() != 0 || exp_rsd_q.size() != 0) && n < 200) begin tick(); n++; end
    n_cmp++;
    if (exp_rss_q.size() != 0 || exp_rsd_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: rss left %0d rsd left %0d, expected 0 0",
               exp_rss_q.size(), exp_rsd_q.size());
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (o_rqa_rdy !== 1'b0) begin n_bad++; $display("FAIL rdy_in_reset: got %b, expected 0", o_rqa_rdy); end
    rst = 1'b0;
    n_cmp++;
    if ({o_rss_vld, o_rsd_vld, o_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: rss_vld/rsd_vld/err got %b%b%b, expected 000", o_rss_vld, o_rsd_vld, o_err);
    end
    n_cmp++;
    if (o_rss !== 9'd0 || o_rsd !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_data: rss %h rsd %h, expected 0 0", o_rss, o_rsd);
    end
    n = 0;
    while (!o_rqa_rdy && n < 16) begin tick(); n++; end
    n_cmp++;
    if (o_rqa_rdy !== 1'b1) begin n_bad++; $display("FAIL rdy_after_reset: got %b, expected 1", o_rqa_rdy); end
  endtask

  task automatic test_write_read();
    bit ok;
    int n;
    issue_write(37'd5, 64'h1122334455667788, 8'hFF);
    issue_read(37'd5, 2'd1, 3'd3, 1'b0, 32, ok);
    n = 0;
    while (!o_rss_vld && n < 20) begin tick(); n++; end
    n_cmp++;
    if (n != READ_LAT - 1) begin
      n_bad++;
      $display("FAIL read_latency: response %0d cycles after accept, expected %0d", n + 1, READ_LAT);
    end
    n_cmp++;
    if (o_rsd !== 64'h1122334455667788 || o_rss[8] !== 1'b0) begin
      n_bad++;
      $display("FAIL read_data: rsd %h err %b, expected 1122334455667788 0", o_rsd, o_rss[8]);
    end
    wait_drain();
  endtask

  task automatic test_pending_write();
    bit ok;
    int n;
    issue_write(37'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    send_rqa({1'b0, 2'd0, 3'd0, 1'b0, 37'd7}, 32, ok);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (o_rqa_rdy !== 1'b0) begin n_bad++; $display("FAIL pend_blocks_rqa: gap %0d rdy %b, expected 0", g, o_rqa_rdy); end
      tick();
    end
    send_rqd(64'd0, 8'h0F, ok);
    mdl[7] = merge(mdl[7], 64'd0, 8'h0F);
    issue_read(37'd7, 2'd0, 3'd1, 1'b1, 32, ok);
    n = 0;
    while (!o_rsd_vld && n < 20) begin tick(); n++; end
    n_cmp++;
    if (o_rsd !== 64'hFFFF_FFFF_0000_0000) begin
      n_bad++;
      $display("FAIL read_after_pend_write: got %h, expected ffffffff00000000", o_rsd);
    end
    wait_drain();
  endtask

  task automatic test_wd_full();
    bit ok;
    bit seen_rdy;
    int n;
    for (int i = 0; i < WD_DEPTH; i++) send_rqd(64'(i), 8'h00, ok);
    seen_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin seen_rdy |= o_rqd_rdy; tick(); end
    n_cmp++;
    if (seen_rdy) begin n_bad++; $display("FAIL wd_full_rdy: rqd_rdy seen 1 with full FIFO, expected 0"); end
    for (int i = 0; i < WD_DEPTH; i++) send_rqa({1'b0, 2'd0, 3'd0, 1'b0, 37'(100 + i)}, 32, ok);
    n = 0;
    while (!o_rqd_rdy && n < 16) begin tick(); n++; end
    n_cmp++;
    if (o_rqd_rdy !== 1'b1) begin n_bad++; $display("FAIL wd_drain_rdy: got %b, expected 1", o_rqd_rdy); end
  endtask

  task automatic test_credits();
    bit ok;
    int acc, n;
    i_rss_rd = 1'b0; i_rsd_rd = 1'b0;
    acc = 0;
    for (int i = 0; i < RS_DEPTH + 1; i++) begin
      issue_read(37'd5, 2'd3, 3'(i), 1'b0, 20, ok);
      if (ok) acc++;
    end
    n_cmp++;
    if (acc != RS_DEPTH) begin n_bad++; $display("FAIL credit_accepts: accepted %0d, expected %0d", acc, RS_DEPTH); end
    n_cmp++;
    if (o_rqa_rdy !== 1'b0) begin n_bad++; $display("FAIL credits_exhausted: rdy %b, expected 0", o_rqa_rdy); end
    repeat (READ_LAT + 2) tick();
    i_rss_rd = 1'b1;
    repeat (RS_DEPTH + 2) tick();
    i_rss_rd = 1'b0;
    n_cmp++;
    if ({o_rss_vld, o_rsd_vld, o_rqa_rdy} !== 3'b010) begin
      n_bad++;
      $display("FAIL rss_only_pop: rss_vld/rsd_vld/rdy got %b%b%b, expected 010", o_rss_vld, o_rsd_vld, o_rqa_rdy);
    end
    i_rsd_rd = 1'b1;
    tick();
    i_rsd_rd = 1'b0;
    n = 0;
    while (!o_rqa_rdy && n < 16) begin tick(); n++; end
    n_cmp++;
    if (o_rqa_rdy !== 1'b1) begin n_bad++; $display("FAIL credit_return: rdy %b, expected 1", o_rqa_rdy); end
    i_rsd_rd = 1'b1; i_rss_rd = 1'b1;
    wait_drain();
  endtask

  task automatic test_fields();
    bit ok;
    for (int t = 0; t < 8; t++) issue_write(37'(16 + t), {32'hA5A5_0000 + 32'(t), 32'h0F0F_0000 + 32'(t * 3)}, 8'hFF);
    i_rss_rd = 1'b0; i_rsd_rd = 1'b0;
    for (int t = 0; t < 8; t++) begin
      issue_read(37'(16 + t), 2'd2, 3'(t), t[0], 32, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL field_read_accept: th %0d not accepted, expected accept", t); end
    end
    for (int k = 0; k < 60; k++) begin
      i_rss_rd = (k % 2) == 0;
      i_rsd_rd = (k % 3) == 0;
      tick();
    end
    i_rss_rd = 1'b1; i_rsd_rd = 1'b1;
    wait_drain();
  endtask

  task automatic test_range();
    bit ok;
    n_cmp++;
    if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_before_range: got %b, expected 0", o_err); end
    issue_read(37'h400, 2'd1, 3'd5, 1'b1, 32, ok);
    n_cmp++;
    if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_on_range_read: got %b, expected 1", o_err); end
    issue_write(37'h10_0000_0005, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    issue_write(37'd1023, 64'h0123_4567_89AB_CDEF, 8'hFF);
    issue_read(37'd1023, 2'd0, 3'd2, 1'b0, 32, ok);
    issue_read(37'd5, 2'd0, 3'd4, 1'b1, 32, ok);
    wait_drain();
    n_cmp++;
    if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b, expected 1", o_err); end
  endtask

  task automatic test_reset_mid();
    bit ok, stale;
    int acc;
    for (int i = 0; i < 3; i++) issue_read(37'd5, 2'd1, 3'(i), 1'b0, 32, ok);
    rst = 1'b1;
    exp_rss_q.delete();
    exp_rsd_q.delete();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({o_rss_vld, o_rsd_vld, o_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset_state: rss_vld/rsd_vld/err got %b%b%b, expected 000", o_rss_vld, o_rsd_vld, o_err);
    end
    stale = 1'b0;
    for (int k = 0; k < 2 * READ_LAT; k++) begin stale |= o_rss_vld | o_rsd_vld; tick(); end
    n_cmp++;
    if (stale) begin n_bad++; $display("FAIL stale_response: vld seen 1 after reset, expected 0"); end
    i_rss_rd = 1'b0; i_rsd_rd = 1'b0;
    acc = 0;
    for (int i = 0; i < RS_DEPTH + 1; i++) begin
      issue_read(37'd7, 2'd2, 3'(i), 1'b1, 20, ok);
      if (ok) acc++;
    end
    n_cmp++;
    if (acc != RS_DEPTH) begin n_bad++; $display("FAIL credits_after_reset: accepted %0d, expected %0d", acc, RS_DEPTH); end
    i_rss_rd = 1'b1; i_rsd_rd = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_pending_write();
    test_wd_full();
    test_credits();
    test_fields();
    test_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
